// File: rtl/bp_cce_inv_sequencer_pkg.sv
// bp_cce_inv_sequencer_pkg: coherence state encodings and the invalidation sequencer FSM states.
package bp_cce_inv_sequencer_pkg;
  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;
  typedef enum logic [1:0] {e_inv_idle, e_inv_send, e_inv_wait, e_inv_done} bp_cce_inv_seq_state_e;
endpackage

// File: rtl/bp_cce_inv_sequencer_picker.sv
// bp_cce_inv_sequencer_picker: lowest-set-bit pick of the pending mask as LCE ID and one-hot.
module bp_cce_inv_sequencer_picker #(
  parameter int num_lce_p = 4,
  parameter int lce_id_width_p = 2
) (
  input  logic [num_lce_p-1:0]      pending_i,
  output logic [num_lce_p-1:0]      one_hot_o,
  output logic [lce_id_width_p-1:0] id_o
);
  assign one_hot_o = pending_i & (~pending_i + num_lce_p'(1));
  always_comb begin
    id_o = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) if (pending_i[i]) id_o = lce_id_width_p'(i);
  end
endmodule

// File: rtl/bp_cce_inv_sequencer.sv
// bp_cce_inv_sequencer: sends one invalidation per cycle to each non-requesting sharer and collects acks.
// Optional ack watchdog enabled by defining BP_CCE_INV_SEQ_TIMEOUT_EN.
module bp_cce_inv_sequencer
  import bp_cce_inv_sequencer_pkg::*;
#(
  parameter int num_lce_p = 4,
  parameter int lce_id_width_p = 2,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p = 40,
  parameter int timeout_cycles_p = 1024,
  localparam int cnt_width_lp = $clog2(num_lce_p + 1),
  localparam int coh_width_lp = $bits(bp_coh_states_e)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   start_v_i,
  output logic                                   start_ready_o,
  input  logic [lce_id_width_p-1:0]              req_lce_i,
  input  logic [paddr_width_p-1:0]               addr_i,
  input  logic [num_lce_p-1:0]                   sharers_hits_i,
  input  logic [num_lce_p*lce_assoc_width_p-1:0] sharers_ways_i,
  input  logic [num_lce_p*coh_width_lp-1:0]      sharers_coh_states_i,
  output logic                                   inv_v_o,
  input  logic                                   inv_ready_i,
  output logic [lce_id_width_p-1:0]              inv_lce_o,
  output logic [lce_assoc_width_p-1:0]           inv_way_o,
  output logic [paddr_width_p-1:0]               inv_addr_o,
  input  logic                                   ack_v_i,
  input  logic [lce_id_width_p-1:0]              ack_lce_i,
  output logic                                   done_v_o,
  input  logic                                   done_yumi_i,
  output logic [cnt_width_lp-1:0]                done_inv_count_o,
  output logic                                   done_had_mod_o,
  output logic                                   busy_o,
  output logic                                   err_o
);
  bp_cce_inv_seq_state_e state_q, state_n;
  logic [num_lce_p-1:0] pending_q, pending_n, outstanding_q, outstanding_n;
  logic [num_lce_p-1:0] snap_pending, inv_oh, ack_oh, req_oh;
  logic [num_lce_p-1:0][lce_assoc_width_p-1:0] ways_q;
  logic [paddr_width_p-1:0] addr_q;
  logic [cnt_width_lp-1:0] count_q, count_n;
  logic [lce_id_width_p-1:0] inv_id;
  logic had_mod_q, had_mod_n, snap_mod, hs, ack_ok, timeout;

  bp_cce_inv_sequencer_picker #(.num_lce_p(num_lce_p), .lce_id_width_p(lce_id_width_p)) picker (
    .pending_i(pending_q),
    .one_hot_o(inv_oh),
    .id_o     (inv_id)
  );

  assign start_ready_o    = state_q == e_inv_idle;
  assign inv_v_o          = state_q == e_inv_send;
  assign done_v_o         = state_q == e_inv_done;
  assign busy_o           = state_q != e_inv_idle;
  assign inv_lce_o        = inv_id;
  assign inv_way_o        = ways_q[inv_id];
  assign inv_addr_o       = addr_q;
  assign done_inv_count_o = count_q;
  assign done_had_mod_o   = had_mod_q;
  assign hs     = inv_v_o & inv_ready_i;
  assign req_oh = num_lce_p'(1) << req_lce_i;
  assign ack_ok = ack_v_i && (state_q == e_inv_send || state_q == e_inv_wait) && outstanding_q[ack_lce_i];
  assign ack_oh = ack_ok ? num_lce_p'(1) << ack_lce_i : '0;

  always_comb begin
    snap_pending = '0;
    snap_mod = 1'b0;
    for (int i = 0; i < num_lce_p; i++) begin
      snap_pending[i] = sharers_hits_i[i] && !req_oh[i]
        && sharers_coh_states_i[i*coh_width_lp +: coh_width_lp] != e_COH_I;
      snap_mod |= snap_pending[i] && sharers_coh_states_i[i*coh_width_lp +: coh_width_lp] == e_COH_M;
    end
  end

  // An ack and a send to a different LCE in the same cycle both land in outstanding_n.
  always_comb begin
    state_n = state_q;
    pending_n = pending_q & ~(hs ? inv_oh : '0);
    outstanding_n = (outstanding_q | (hs ? inv_oh : '0)) & ~ack_oh;
    count_n = count_q + cnt_width_lp'(hs);
    had_mod_n = had_mod_q;
    case (state_q)
      e_inv_idle: if (start_v_i) begin
        state_n = |snap_pending ? e_inv_send : e_inv_done;
        pending_n = snap_pending;
        outstanding_n = '0;
        count_n = '0;
        had_mod_n = snap_mod;
      end
      e_inv_send: state_n = pending_n == '0 ? e_inv_wait : e_inv_send;
      e_inv_wait: state_n = (outstanding_n == '0 || timeout) ? e_inv_done : e_inv_wait;
      e_inv_done: state_n = done_yumi_i ? e_inv_idle : e_inv_done;
      default: state_n = e_inv_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= e_inv_idle;
      pending_q <= '0;
      outstanding_q <= '0;
      count_q <= '0;
      had_mod_q <= 1'b0;
      ways_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_n;
      pending_q <= pending_n;
      outstanding_q <= outstanding_n;
      count_q <= count_n;
      had_mod_q <= had_mod_n;
      if (start_ready_o && start_v_i) begin
        ways_q <= sharers_ways_i;
        addr_q <= addr_i;
      end
    end

`ifdef BP_CCE_INV_SEQ_TIMEOUT_EN
  localparam int timer_width_lp = $clog2(timeout_cycles_p + 1);
  logic [timer_width_lp-1:0] timer_q;
  logic err_q;
  // Timer counts WAIT cycles since the last accepted ack; it is held at zero everywhere else.
  assign timeout = state_q == e_inv_wait && !ack_ok && timer_q == timer_width_lp'(timeout_cycles_p - 1);
  assign err_o = err_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      timer_q <= '0;
      err_q <= 1'b0;
    end else begin
      timer_q <= (state_q != e_inv_wait || ack_ok) ? '0 : timer_q + timer_width_lp'(1);
      err_q <= err_q | timeout;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_p;
  assign timeout = 1'b0;
  assign err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (reset_n_i && ack_v_i && (state_q == e_inv_send || state_q == e_inv_wait))
      assert (outstanding_q[ack_lce_i]) else $error("ack from non-outstanding LCE %0d", ack_lce_i);
`endif
endmodule

// File: tb/tb_bp_cce_inv_sequencer.sv
// tb_bp_cce_inv_sequencer: vector table, directed corner cases and random transactions against a transaction-level model.
module tb_bp_cce_inv_sequencer;
  import bp_cce_inv_sequencer_pkg::*;
`ifdef BP_CCE_INV_SEQ_TIMEOUT_EN
  localparam int to_lp = 16;
`else
  localparam int to_lp = 1024;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic start_v = 1'b0, start_ready_o;
  logic [1:0] req_lce = '0;
  logic [39:0] addr_in = '0;
  logic [3:0] hits_in = '0;
  logic [11:0] ways_in = '0, states_in = '0;
  logic inv_v_o, inv_ready = 1'b0;
  logic [1:0] inv_lce_o;
  logic [2:0] inv_way_o;
  logic [39:0] inv_addr_o;
  logic ack_v = 1'b0;
  logic [1:0] ack_lce = '0;
  logic done_v_o, done_yumi = 1'b0;
  logic [2:0] done_inv_count_o;
  logic done_had_mod_o, busy_o, err_o;
  int checks = 0, errors = 0;

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  hits;
    logic [11:0] st;
    int          stall;
    logic [3:0]  mask;
    logic        mod;
  } vec_t;
  vec_t vt[8];

  bp_cce_inv_sequencer #(.timeout_cycles_p(to_lp)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .start_v_i(start_v), .start_ready_o(start_ready_o),
    .req_lce_i(req_lce), .addr_i(addr_in),
    .sharers_hits_i(hits_in), .sharers_ways_i(ways_in), .sharers_coh_states_i(states_in),
    .inv_v_o(inv_v_o), .inv_ready_i(inv_ready), .inv_lce_o(inv_lce_o),
    .inv_way_o(inv_way_o), .inv_addr_o(inv_addr_o),
    .ack_v_i(ack_v), .ack_lce_i(ack_lce),
    .done_v_o(done_v_o), .done_yumi_i(done_yumi),
    .done_inv_count_o(done_inv_count_o), .done_had_mod_o(done_had_mod_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Targets are every hitting, non-invalid sharer except the requester.
  function automatic logic [4:0] model(input logic [1:0] req, input logic [3:0] hits, input logic [11:0] st);
    logic [3:0] m = '0;
    logic mod = 1'b0;
    for (int i = 0; i < 4; i++)
      if (hits[i] && i != int'(req) && st[i*3 +: 3] != e_COH_I) begin
        m[i] = 1'b1;
        mod |= st[i*3 +: 3] == e_COH_M;
      end
    return {mod, m};
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic run_txn(input logic [1:0] req, input logic [3:0] hits, input logic [11:0] st,
                         input int stall, input bit rnd, input logic [3:0] exp_mask, input logic exp_mod);
    logic [11:0] ways = 12'($urandom);
    logic [39:0] addr = {8'($urandom), $urandom};
    logic [3:0] left = exp_mask, sent = '0;
    int due[4];
    bit done = 1'b0, prev_stall = 1'b0;
    logic [1:0] p_lce = '0;
    logic [2:0] p_way = '0;
    for (int k = 0; k < 50 && !start_ready_o; k++) @(negedge clk);
    chk("start_ready", start_ready_o, 1);
    start_v = 1'b1; req_lce = req; addr_in = addr; hits_in = hits; ways_in = ways; states_in = st;
    @(negedge clk);
    start_v = 1'b0; hits_in = 4'($urandom); ways_in = 12'($urandom); addr_in = '1;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      ack_v = 1'b0;
      inv_ready = 1'b0;
      if (done_v_o) begin
        chk("done_count", done_inv_count_o, $countones(exp_mask));
        chk("done_mod", done_had_mod_o, exp_mod);
        chk("all_sent", left, 0);
        chk("all_acked", sent, 0);
        chk("err_clear", err_o, 0);
        if (exp_mask == 0) chk("empty_latency", cyc, 1);
        done_yumi = 1'b1;
        done = 1'b1;
      end else begin
        if (prev_stall) begin
          chk("hold_lce", inv_lce_o, p_lce);
          chk("hold_way", inv_way_o, p_way);
          chk("hold_addr", inv_addr_o, addr);
        end
        for (int i = 0; i < 4; i++)
          if (sent[i] && due[i] <= cyc && !ack_v) begin
            ack_v = 1'b1;
            ack_lce = 2'(i);
            sent[i] = 1'b0;
          end
        inv_ready = cyc > stall && (!rnd || $urandom_range(0, 99) < 70);
        prev_stall = inv_v_o && !inv_ready;
        p_lce = inv_lce_o;
        p_way = inv_way_o;
        if (inv_v_o && inv_ready) begin
          chk("inv_lce", inv_lce_o, lowest(left));
          chk("inv_way", inv_way_o, ways[inv_lce_o*3 +: 3]);
          chk("inv_addr", inv_addr_o, addr);
          left[inv_lce_o] = 1'b0;
          sent[inv_lce_o] = 1'b1;
          due[inv_lce_o] = cyc + (rnd ? int'($urandom_range(1, 4)) : 1);
        end
      end
      @(negedge clk);
    end
    done_yumi = 1'b0;
    ack_v = 1'b0;
    inv_ready = 1'b0;
    if (!done) chk("done_wait_expired", 0, 1);
  endtask

  initial begin
    vt[0] = '{2'd1, 4'b1011, {4{e_COH_S}}, 0, 4'b1001, 1'b0};
    vt[1] = '{2'd1, 4'b0010, {4{e_COH_S}}, 0, 4'b0000, 1'b0};
    vt[2] = '{2'd0, 4'b1100, {e_COH_M, e_COH_S, e_COH_S, e_COH_S}, 3, 4'b1100, 1'b1};
    vt[3] = '{2'd1, 4'b0101, {4{e_COH_S}}, 0, 4'b0101, 1'b0};
    vt[4] = '{2'd2, 4'b1111, {e_COH_I, e_COH_M, e_COH_E, e_COH_O}, 0, 4'b0011, 1'b0};
    vt[5] = '{2'd3, 4'b1111, {4{e_COH_M}}, 1, 4'b0111, 1'b1};
    vt[6] = '{2'd0, 4'b0000, {4{e_COH_M}}, 0, 4'b0000, 1'b0};
    vt[7] = '{2'd0, 4'b1110, {e_COH_S, e_COH_I, e_COH_F, e_COH_M}, 2, 4'b1010, 1'b0};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", start_ready_o, 1);
    chk("rst_inv_v", inv_v_o, 0);
    chk("rst_done_v", done_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);

    foreach (vt[i]) run_txn(vt[i].req, vt[i].hits, vt[i].st, vt[i].stall, 1'b0, vt[i].mask, vt[i].mod);

    // Asynchronous reset in the middle of a stalled send; no partial completion may follow.
    start_v = 1'b1; req_lce = 2'd1; hits_in = 4'b1101; states_in = {4{e_COH_S}};
    @(negedge clk);
    start_v = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_inv_v", inv_v_o, 0);
    chk("mid_rst_done_v", done_v_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", start_ready_o, 1);
    inv_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", done_v_o, 0);
    chk("post_rst_no_inv", inv_v_o, 0);
    inv_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic [1:0] req = 2'($urandom_range(0, 3));
      logic [3:0] hits = 4'($urandom);
      logic [11:0] st;
      logic [4:0] e;
      bp_coh_states_e pick[6] = '{e_COH_I, e_COH_S, e_COH_E, e_COH_F, e_COH_M, e_COH_O};
      for (int i = 0; i < 4; i++) st[i*3 +: 3] = pick[$urandom_range(0, 5)];
      e = model(req, hits, st);
      run_txn(req, hits, st, int'($urandom_range(0, 2)), 1'b1, e[3:0], e[4]);
    end

`ifdef BP_CCE_INV_SEQ_TIMEOUT_EN
    begin
      int waits = 0;
      bit seen = 1'b0;
      start_v = 1'b1; req_lce = 2'd0; hits_in = 4'b0110; states_in = {4{e_COH_S}};
      @(negedge clk);
      start_v = 1'b0;
      inv_ready = 1'b1;
      for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
        ack_v = cyc == 2;
        ack_lce = 2'd1;
        if (done_v_o) seen = 1'b1;
        else if (busy_o && !inv_v_o) waits++;
        if (!seen) @(negedge clk);
      end
      ack_v = 1'b0;
      inv_ready = 1'b0;
      chk("to_done", done_v_o, 1);
      chk("to_wait_cycles", waits, 16);
      chk("to_err", err_o, 1);
      chk("to_count", done_inv_count_o, 2);
      done_yumi = 1'b1;
      @(negedge clk);
      done_yumi = 1'b0;
      @(negedge clk);
      chk("to_err_sticky", err_o, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
